trng_top: RTL and testbench

- Top-level random-number engine of the security engine.
- Holds a 256-bit internal state and a free-running 64-bit LFSR entropy source.
- On a one-cycle TRNG_Go command, performs the operation selected by Op_Type (instantiate, reseed, generate with additional input, generate), runs 16 mixing rounds and presents a 256-bit result on data_out with TRNG_Done held high.
- Fully deterministic relative to reset, so a cycle-accurate reference model can check it.

---
 rtl/trng_top.sv | 134 +++++++++++++
 tb/tb_trng_top.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trng_top.sv
// Random-number engine: 256-bit state mixed with a free-running 64-bit LFSR.
// A one-cycle TRNG_Go runs instantiate/reseed/generate and holds the result.
module trng_top #(
    parameter int unsigned ROUNDS    = 16,
    parameter logic [63:0] LFSR_SEED = 64'h0000_0000_0000_0001
) (
    input  logic         clk,
    input  logic         Resetn,
    input  logic         TRNG_Go,
    input  logic [1:0]   Op_Type,
    input  logic [511:0] data_in,
    output logic         TRNG_Done,
    output logic [255:0] data_out
);

    localparam int unsigned RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_MIX  = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_UPD  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [1:0] OP_INST = 2'b00;
    localparam logic [1:0] OP_RESD = 2'b01;
    localparam logic [1:0] OP_GENA = 2'b10;

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [255:0]     s_q, s_d;
    logic [63:0]      l_q, l_d;
    logic             inst_q, inst_d;
    logic [255:0]     data_out_q, data_out_d;
    logic             done_q, done_d;
    logic [RND_W-1:0] rnd_q, rnd_d;

    // One xorshift-style mixing round with LFSR injection into the low word.
    function automatic logic [255:0] mix_round(input logic [255:0] s, input logic [63:0] l);
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] c;
        a = s ^ (s << 13);
        b = a ^ (a >> 7);
        c = b ^ (b << 17);
        return c ^ {192'b0, l};
    endfunction

    // Next-state logic: LFSR always steps, FSM sequences load/mix/out/update.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        s_d        = s_q;
        inst_d     = inst_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        rnd_d      = rnd_q;
        l_d        = {l_q[62:0], l_q[63] ^ l_q[62] ^ l_q[60] ^ l_q[59]};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (TRNG_Go) begin
                    op_d    = Op_Type;
                    done_d  = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                case (op_q)
                    OP_INST: begin
                        s_d    = data_in[511:256] ^ data_in[255:0];
                        inst_d = 1'b1;
                    end
                    OP_RESD: s_d = s_q ^ data_in[511:256] ^ data_in[255:0];
                    OP_GENA: s_d = s_q ^ data_in[255:0];
                    default: s_d = s_q;
                endcase
                // Anything but instantiate on an uninstantiated engine is refused.
                if ((op_q != OP_INST) && !inst_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rnd_d   = '0;
                    state_d = ST_MIX;
                end
            end
            ST_MIX: begin
                s_d   = mix_round(s_q, l_q);
                rnd_d = rnd_q + RND_W'(1);
                if (rnd_q == RND_W'(ROUNDS - 1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                data_out_d = s_q;
                state_d    = ST_UPD;
            end
            ST_UPD: begin
                // Post-output state update so the published value cannot be walked back.
                s_d     = mix_round(s_q, l_q);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (Resetn) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            s_q        <= '0;
            l_q        <= LFSR_SEED;
            inst_q     <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            rnd_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            s_q        <= s_d;
            l_q        <= l_d;
            inst_q     <= inst_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            rnd_q      <= rnd_d;
        end
    end

    assign TRNG_Done = done_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_trng_top.sv
// Self-checking bench for trng_top: transaction model plus result scoreboard.
module tb_trng_top;

    localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;

    logic         clk = 1'b0;
    logic         Resetn;
    logic         TRNG_Go;
    logic [1:0]   Op_Type;
    logic [511:0] data_in;
    logic         TRNG_Done;
    logic [255:0] data_out;

    int n_cmp = 0;
    int n_mis = 0;

    trng_top dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .TRNG_Go   (TRNG_Go),
        .Op_Type   (Op_Type),
        .data_in   (data_in),
        .TRNG_Done (TRNG_Done),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    function automatic logic [255:0] ref_round(input logic [255:0] s, input logic [63:0] l);
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] c;
        a = s ^ (s << 13);
        b = a ^ (a >> 7);
        c = b ^ (b << 17);
        return c ^ {192'b0, l};
    endfunction

    // Reference entropy source, advanced at every edge exactly as described.
    logic [63:0] ref_l;
    always @(posedge clk) begin
        if (Resetn) ref_l <= SEED;
        else        ref_l <= lfsr_step(ref_l);
    end

    // Transaction-level model state.
    logic [255:0] m_s;
    logic         m_inst;
    logic [255:0] m_last;
    logic [255:0] exp_q[$];

    task automatic model_reset();
        m_s    = '0;
        m_inst = 1'b0;
        m_last = '0;
        exp_q.delete();
    endtask

    // Predict the result of an operation whose Go edge sees LFSR value l0.
    task automatic predict(input logic [1:0] op, input logic [511:0] din,
                           input logic [63:0] l0, output logic [255:0] exp_o);
        logic [63:0]  l;
        logic [255:0] d;
        logic         was_inst;
        l        = lfsr_step(l0);
        d        = din[511:256] ^ din[255:0];
        was_inst = m_inst;
        case (op)
            2'b00: begin m_s = d; m_inst = 1'b1; end
            2'b01: m_s = m_s ^ d;
            2'b10: m_s = m_s ^ din[255:0];
            default: ;
        endcase
        if (op != 2'b00 && !was_inst) begin
            exp_o = m_last;
        end else begin
            for (int j = 0; j < 16; j++) begin
                l   = lfsr_step(l);
                m_s = ref_round(m_s, l);
            end
            exp_o  = m_s;
            m_last = m_s;
            l      = lfsr_step(l);
            l      = lfsr_step(l);
            m_s    = ref_round(m_s, l);
        end
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Resetn = 1'b0;
        model_reset();
    endtask

    // Issue one operation from a negedge and check latency and result.
    task automatic run_op(input string name, input logic [1:0] op, input logic [511:0] din,
                          input int exp_lat, input int glitch_at);
        logic [255:0] e;
        int cnt;
        predict(op, din, ref_l, e);
        exp_q.push_back(e);
        TRNG_Go = 1'b1;
        Op_Type = op;
        data_in = din;
        @(posedge clk);
        @(negedge clk);
        TRNG_Go = 1'b0;
        cnt = 0;
        chk({name, "_done_drop"}, 256'(TRNG_Done), 256'd0);
        while (!TRNG_Done && cnt < 60) begin
            if (cnt == glitch_at) begin
                TRNG_Go = 1'b1;
                Op_Type = ~op;
                data_in = {16{$urandom}};
            end else begin
                TRNG_Go = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        TRNG_Go = 1'b0;
        chk({name, "_latency"}, 256'(cnt), 256'(exp_lat));
        chk({name, "_done"}, 256'(TRNG_Done), 256'd1);
        e = exp_q.pop_front();
        chk({name, "_data"}, data_out, e);
    endtask

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [511:0] din;
        int           lat;
    } vec_t;

    vec_t vecs[4];
    logic [255:0] outs[4];

    initial begin
        vecs[0] = '{"inst",  2'b00, 512'd1452664, 19};
        vecs[1] = '{"gen_ai", 2'b10, 512'd323464, 19};
        vecs[2] = '{"gen_a", 2'b11, 512'd0,      19};
        vecs[3] = '{"gen_b", 2'b11, 512'd0,      19};

        Resetn  = 1'b1;
        TRNG_Go = 1'b0;
        Op_Type = 2'b00;
        data_in = '0;
        @(negedge clk);
        do_reset();
        chk("reset_data", data_out, '0);
        chk("reset_done", 256'(TRNG_Done), 256'd0);

        // Idle with no Go: nothing moves on the outputs.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_done", 256'(TRNG_Done), 256'd0);
            chk("idle_data", data_out, '0);
        end

        // Main table: instantiate, generate w/ AI, two back-to-back generates.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].din, vecs[i].lat, -1);
            outs[i] = data_out;
        end
        chk("inst_nonzero", 256'(outs[0] != '0), 256'd1);
        chk("ai_differs",   256'(outs[1] != outs[0]), 256'd1);
        chk("gen_distinct", 256'(outs[3] != outs[2]), 256'd1);

        // Generate before instantiate is refused; then instantiate with zero seed.
        do_reset();
        run_op("uninst_gen", 2'b11, 512'd0, 1, -1);
        chk("uninst_zero", data_out, '0);
        run_op("zero_inst", 2'b00, 512'd0, 19, -1);
        chk("zero_inst_nonzero", 256'(data_out != '0), 256'd1);

        // Reseed, then a Go pulse mid-MIX must be ignored.
        run_op("reseed", 2'b01, {256'hdead_beef, 256'h1234_5678}, 19, -1);
        run_op("glitch", 2'b11, 512'd0, 19, 8);

        // Reset mid-MIX discards everything; a fresh instantiate follows.
        TRNG_Go = 1'b1;
        Op_Type = 2'b00;
        data_in = 512'd777;
        @(posedge clk);
        @(negedge clk);
        TRNG_Go = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();
        chk("abort_data", data_out, '0);
        chk("abort_done", 256'(TRNG_Done), 256'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_idle_done", 256'(TRNG_Done), 256'd0);
        run_op("post_abort", 2'b00, 512'd1452664, 19, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
